// File: rtl/md5_round_sched.sv
// md5_round_sched: sequences one 512-bit block through the 64 MD5 rounds.
// A start pulse taken in IDLE produces a one-cycle chaining-value load
// (init_en), then 64 rounds, then a one-cycle chaining-value accumulate
// (final_en), then a registered one-cycle done pulse back in IDLE.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; counter held at 0; done may pulse here
// INIT  | init_en strobe: load A-D from the chaining registers
// RUN   | one round per cycle while hold=0; hold freezes the counter
// FINAL | final_en strobe: add A-D into the chaining registers
module md5_round_sched (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       hold_i,
  output logic       busy_o,
  output logic       init_en_o,
  output logic       round_valid_o,
  output logic [5:0] round_idx_o,
  output logic [3:0] msg_idx_o,
  output logic [1:0] func_sel_o,
  output logic [1:0] shift_sel_o,
  output logic       final_en_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    FINAL = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [3:0] i_lo;

  // State, round counter and done register; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and the combinational round_valid strobe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    round_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 6'd0;
        if (start_i) state_d = INIT;
      end
      INIT: begin
        state_d = RUN;
      end
      RUN: begin
        round_valid_o = ~hold_i;
        if (!hold_i) begin
          if (cnt_q == 6'd63) begin
            cnt_d   = 6'd0;
            state_d = FINAL;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      FINAL: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Message word index g, shift/add only, everything mod 16.
  always_comb begin
    i_lo = cnt_q[3:0];
    case (cnt_q[5:4])
      2'b00:   msg_idx_o = i_lo;
      2'b01:   msg_idx_o = (i_lo << 2) + i_lo + 4'd1;
      2'b10:   msg_idx_o = (i_lo << 1) + i_lo + 4'd5;
      default: msg_idx_o = (i_lo << 3) - i_lo;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign init_en_o   = (state_q == INIT);
  assign final_en_o  = (state_q == FINAL);
  assign done_o      = done_q;
  assign round_idx_o = cnt_q;
  assign func_sel_o  = cnt_q[5:4];
  assign shift_sel_o = cnt_q[1:0];

endmodule

// File: tb/tb_md5_round_sched.sv
// Bench for md5_round_sched: directed scenarios plus random start/hold/reset,
// checked every cycle against a block-position model of the schedule.
module tb_md5_round_sched;

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, hold_i;
  logic       busy_o, init_en_o, round_valid_o, final_en_o, done_o;
  logic [5:0] round_idx_o;
  logic [3:0] msg_idx_o;
  logic [1:0] func_sel_o, shift_sel_o;

  md5_round_sched dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .hold_i(hold_i),
    .busy_o(busy_o), .init_en_o(init_en_o), .round_valid_o(round_valid_o),
    .round_idx_o(round_idx_o), .msg_idx_o(msg_idx_o), .func_sel_o(func_sel_o),
    .shift_sel_o(shift_sel_o), .final_en_o(final_en_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model: m_act = block in progress; m_pos = 0 load, 1..64 round pos-1, 65 accumulate.
  bit m_act  = 1'b0;
  int m_pos  = 0;
  bit m_done = 1'b0;

  int done_cyc[$];
  int init_cyc[$];

  int spot_round[5] = '{5, 17, 33, 50, 63};
  int spot_g[5]     = '{5, 6, 8, 14, 9};

  function automatic int g_of(int i);
    case (i / 16)
      0:       return i;
      1:       return (5 * i + 1) % 16;
      2:       return (3 * i + 5) % 16;
      default: return (7 * i) % 16;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step(input bit s, input bit h, input bit r);
    bit in_round;
    int e_ridx;
    start_i = s;
    hold_i  = h;
    reset_i = r;
    @(negedge clk_i);
    in_round = m_act && m_pos >= 1 && m_pos <= 64;
    e_ridx   = in_round ? m_pos - 1 : 0;
    chk("busy",        busy_o,        m_act);
    chk("init_en",     init_en_o,     m_act && m_pos == 0);
    chk("round_valid", round_valid_o, in_round && !h);
    chk("round_idx",   round_idx_o,   e_ridx);
    chk("msg_idx",     msg_idx_o,     g_of(e_ridx));
    chk("func_sel",    func_sel_o,    e_ridx / 16);
    chk("shift_sel",   shift_sel_o,   e_ridx % 4);
    chk("final_en",    final_en_o,    m_act && m_pos == 65);
    chk("done",        done_o,        m_done);
    if (in_round && !h)
      for (int k = 0; k < 5; k++)
        if (e_ridx == spot_round[k]) chk("g_spot", msg_idx_o, spot_g[k]);
    if (done_o === 1'b1)    done_cyc.push_back(cyc);
    if (init_en_o === 1'b1) init_cyc.push_back(cyc);
    @(posedge clk_i);
    if (r) begin
      m_act = 0; m_pos = 0; m_done = 0;
    end else begin
      m_done = m_act && m_pos == 65;
      if (!m_act) begin
        if (s) begin m_act = 1; m_pos = 0; end
      end else if (m_pos == 0) m_pos = 1;
      else if (m_pos <= 64) begin
        if (!h) m_pos++;
      end else begin
        m_act = 0; m_pos = 0;
      end
    end
    cyc++;
    #1;
  endtask

  int t0, holds;

  initial begin
    start_i = 0; hold_i = 0; reset_i = 1;
    @(posedge clk_i); #1;
    step(0, 0, 1);
    step(0, 0, 0);

    // Nominal single block.
    done_cyc.delete(); init_cyc.delete();
    t0 = cyc;
    step(1, 0, 0);
    for (int k = 0; k < 70; k++) step(0, 0, 0);
    chk("nom_done_count", done_cyc.size(), 1);
    chk("nom_done_time",  (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 67);
    chk("nom_init_time",  (init_cyc.size() > 0) ? init_cyc[0] - t0 : -1, 1);

    // Three hold cycles at round 20, plus hold during load and accumulate.
    done_cyc.delete();
    holds = 0;
    t0 = cyc;
    step(1, 0, 0);
    for (int k = 0; k < 80; k++) begin
      if (m_act && m_pos == 21 && holds < 3) begin
        holds++;
        step(0, 1, 0);
      end else
        step(0, m_act && (m_pos == 0 || m_pos == 65), 0);
    end
    chk("hold_done_count", done_cyc.size(), 1);
    chk("hold_done_time",  (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 70);

    // Start pulsed at round 10 is ignored.
    done_cyc.delete(); init_cyc.delete();
    step(1, 0, 0);
    for (int k = 0; k < 75; k++) step(m_act && m_pos == 11, 0, 0);
    chk("busy_start_dones", done_cyc.size(), 1);
    chk("busy_start_inits", init_cyc.size(), 1);

    // Reset at round 40 aborts, then a nominal block follows.
    done_cyc.delete();
    step(1, 0, 0);
    for (int k = 0; k < 45 && !(m_act && m_pos == 41); k++) step(0, 0, 0);
    chk("abort_at_round40", m_pos, 41);
    step(0, 0, 1);
    for (int k = 0; k < 40; k++) step(0, 0, 0);
    chk("abort_no_done", done_cyc.size(), 0);
    t0 = cyc;
    step(1, 0, 0);
    for (int k = 0; k < 70; k++) step(0, 0, 0);
    chk("post_abort_done", (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 67);

    // Start held high: back-to-back blocks on a 67-cycle period.
    done_cyc.delete(); init_cyc.delete();
    for (int k = 0; k < 3 * 67 + 3; k++) step(1, 0, 0);
    step(0, 0, 0);
    chk("b2b_init_count", init_cyc.size(), 4);
    for (int k = 1; k < init_cyc.size(); k++)
      chk("b2b_period", init_cyc[k] - init_cyc[k-1], 67);
    for (int k = 0; k < done_cyc.size() && k + 1 < init_cyc.size(); k++)
      chk("b2b_done_to_init", init_cyc[k+1] - done_cyc[k], 1);
    for (int k = 0; k < 70; k++) step(0, 0, 0);

    // Random start/hold/reset traffic.
    for (int k = 0; k < 1500; k++)
      step($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(199) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
